div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Iterative radix-2 restoring divider for the execute stage (DIV/DIVU).
//  Fed by the EX-stage operands and the decoded divide request; raises a stall
//  request that the hazard unit ORs into stallE/stallM. Returns {HI,LO} for the
//  HI/LO write path, together with HLwrite.
//  Provides the multi-cycle stall source for the pipeline control.
// PARAMETERS
//  WIDTH  32  operand width; quotient and remainder are each WIDTH bits
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        asynchronous, active-low reset
//  start        in   1        EX holds a DIV/DIVU (decoded from alucontrolE)
//  signed_div   in   1        1 = DIV (signed), 0 = DIVU; sampled with start
//  opa          in   WIDTH    dividend (rs); sampled with start
//  opb          in   WIDTH    divisor (rt); sampled with start
//  annul        in   1        flush of the owning instruction; aborts the operation
//  stall_req    out  1        hold the pipeline while a divide is in flight
//  result_valid out  1        one-cycle pulse: result is valid this cycle
//  result       out  2*WIDTH  {HI=remainder, LO=quotient}
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, counter=0, stall_req=0, result_valid=0, result=0.
//  States:
//   IDLE: start&~annul & opb!=0 -> DIV. start&~annul & opb==0 -> DONE. Else stay.
//   DIV:  one quotient bit per cycle, WIDTH cycles (counter WIDTH-1 down to 0).
//         annul -> IDLE. counter==0 -> DONE.
//   DONE: result_valid=1 for exactly one cycle -> IDLE (annul in DONE: valid is
//         suppressed, then -> IDLE).
//  Latency: start in cycle T -> result_valid in cycle T+WIDTH+1 (T+1 when dividing
//   by zero).
//  stall_req = (IDLE & start & ~annul) | DIV. It is 0 in DONE, so the pipeline
//   advances and writes HI/LO in the same cycle result_valid=1. The pipeline keeps
//   start asserted while stalled; start is ignored outside IDLE.
//  On accept, the unit latches magnitudes |opa| and |opb| (signed_div only),
//   neg_q = signed_div & (opa[MSB]^opb[MSB]), and neg_r = signed_div & opa[MSB].
//  Iteration: partial remainder P is WIDTH+1 bits. Shift {P,Q} left by 1 and trial
//   P-|opb|. If the trial is non-negative, keep it and set Q[0]=1. Else Q[0]=0.
//  Final sign fix-up (in DONE): LO = neg_q ? -Q : Q; HI = neg_r ? -R : R, modulo 2^WIDTH.
//  -2^31 / -1 -> LO=32'h8000_0000, HI=0 (wraps, no trap).
//  Divide by zero -> HI=opa, LO=32'hFFFF_FFFF. This fixed value is chosen for
//   determinism.
//  result holds its last value outside DONE. Consumers use it only while
//   result_valid=1.
//  annul has priority over start in the same cycle. After annul, a new start is
//   accepted the cycle after return to IDLE.
//  Reset mid-operation: immediate return to the reset state, and no result_valid.
// TESTING
//  DIVU 100/7 -> stall_req 1 for 33 cycles, then result_valid with HI=2, LO=14 (0x0000_0002_0000_000E).
//  DIV -7/2 -> LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1); DIV 7/-2 -> LO=-3, HI=1.
//  DIV 0x8000_0000 / 0xFFFF_FFFF -> LO=0x8000_0000, HI=0; DIVU 0xFFFF_FFFF/1 -> LO=0xFFFF_FFFF, HI=0.
//  Divide by zero, opa=0x1234 -> result_valid at T+1, HI=0x1234, LO=0xFFFF_FFFF.
//  Abort: annul at iteration 10 -> IDLE next cycle, stall_req 0, no result_valid.
//   A following DIVU 9/3 returns LO=3, HI=0.
//  Pull rst low at iteration 20 -> all outputs 0 asynchronously. After release,
//   start with 0 in IDLE keeps stall_req=0.

Source files
------------

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
// Iterative radix-2 restoring divider for the execute stage (DIV / DIVU).
// Produces one quotient bit per cycle and holds the pipeline through a
// stall request while a divide is in flight. The {HI, LO} result is
// presented together with a one-cycle result_valid pulse.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-low reset
//   start        in   EX stage holds a DIV/DIVU; held high while stalled
//   signed_div   in   1 = DIV (signed), 0 = DIVU; sampled with start
//   opa          in   dividend (rs); sampled with start
//   opb          in   divisor (rt); sampled with start
//   annul        in   flush of the owning instruction; aborts the operation
//   stall_req    out  hold the pipeline while a divide is in flight
//   result_valid out  one-cycle pulse: result is valid this cycle
//   result       out  {HI = remainder, LO = quotient}
// ---------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opa,
    input  logic [WIDTH-1:0]   opb,
    input  logic               annul,
    output logic               stall_req,
    output logic               result_valid,
    output logic [2*WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [CW-1:0]      r_cnt;
    // The restored partial remainder is always below the divisor, so it fits
    // in WIDTH bits; only the shifted trial value needs the extra bit.
    logic [WIDTH-1:0]   r_p;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_b;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [2*WIDTH-1:0] r_result;

    logic               w_accept;
    logic               w_div_zero;
    logic               w_last;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_p_shift;
    logic               w_fits;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_p_next;
    logic [WIDTH-1:0]   w_q_next;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    // Gating with rst keeps stall_req low while reset is held even if the
    // pipeline still presents start.
    assign w_accept   = rst & (r_state == S_IDLE) & start & ~annul;
    assign w_div_zero = (opb == '0);
    assign w_last     = (r_cnt == '0);

    // Magnitudes; the most negative value maps onto itself, which is the
    // correct unsigned magnitude 2^(WIDTH-1).
    assign w_abs_a = (signed_div & opa[WIDTH-1]) ? -opa : opa;
    assign w_abs_b = (signed_div & opb[WIDTH-1]) ? -opb : opb;

    // One restoring step: shift {P,Q} left, trial-subtract the divisor.
    assign w_p_shift = {r_p, r_q[WIDTH-1]};
    assign w_fits    = (w_p_shift >= {1'b0, r_b});
    assign w_diff    = w_p_shift[WIDTH-1:0] - r_b;
    assign w_p_next  = w_fits ? w_diff : w_p_shift[WIDTH-1:0];
    assign w_q_next  = {r_q[WIDTH-2:0], w_fits};

    // Sign fix-up of the final step, wrapping modulo 2^WIDTH.
    assign w_quot = r_neg_q ? -w_q_next : w_q_next;
    assign w_rem  = r_neg_r ? -w_p_next : w_p_next;

    assign result = r_result;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        w_state_next = r_state;
        stall_req    = 1'b0;
        result_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    stall_req    = 1'b1;
                    w_state_next = w_div_zero ? S_DONE : S_DIV;
                end
            end
            S_DIV: begin
                stall_req = 1'b1;
                if (annul) begin
                    w_state_next = S_IDLE;
                end else if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                result_valid = ~annul;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_p      <= '0;
            r_q      <= '0;
            r_b      <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_p     <= '0;
                        r_q     <= w_abs_a;
                        r_b     <= w_abs_b;
                        r_neg_q <= signed_div & (opa[WIDTH-1] ^ opb[WIDTH-1]);
                        r_neg_r <= signed_div & opa[WIDTH-1];
                        r_cnt   <= CW'(WIDTH - 1);
                        // Divide by zero skips iteration with a fixed answer.
                        if (w_div_zero) begin
                            r_result <= {opa, {WIDTH{1'b1}}};
                        end
                    end
                end
                S_DIV: begin
                    if (!annul) begin
                        r_p   <= w_p_next;
                        r_q   <= w_q_next;
                        r_cnt <= r_cnt - CW'(1);
                        // Result lands on entry to DONE and then holds.
                        if (w_last) begin
                            r_result <= {w_rem, w_quot};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit
// Self-checking bench for div_unit. A timestamp-based reference model
// predicts stall_req / result_valid / result every cycle; the expected
// quotient and remainder come from plain integer division.
// ---------------------------------------------------------------------------
module tb_div_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           signed_div;
    logic [W-1:0]   opa;
    logic [W-1:0]   opb;
    logic           annul;
    logic           stall_req;
    logic           result_valid;
    logic [2*W-1:0] result;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .signed_div   (signed_div),
        .opa          (opa),
        .opb          (opb),
        .annul        (annul),
        .stall_req    (stall_req),
        .result_valid (result_valid),
        .result       (result)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference divide: {HI = remainder, LO = quotient}, truncating division.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Cycle-level model: an accepted op in cycle T is busy in T+1..T_done-1
    // and delivers in T_done (T+W+1, or T+1 for a zero divisor).
    int          m_cyc = 0;
    bit          m_have = 1'b0;
    int          m_t_acc = 0;
    int          m_t_done = 0;
    logic [63:0] m_exp = '0;

    initial begin : model_compare
        bit in_div;
        bit in_done;
        bit exp_stall;
        bit exp_valid;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (!rst) begin
                    check("reset_stall_req", stall_req, 0);
                    check("reset_result_valid", result_valid, 0);
                    check("reset_result", result, 0);
                    m_have = 1'b0;
                end else begin
                    in_div    = m_have && (m_cyc > m_t_acc) && (m_cyc < m_t_done);
                    in_done   = m_have && (m_cyc == m_t_done);
                    exp_stall = in_div || (!m_have && start && !annul);
                    exp_valid = in_done && !annul;
                    check("stall_req", stall_req, exp_stall);
                    check("result_valid", result_valid, exp_valid);
                    if (exp_valid) check("result", result, m_exp);
                    if (in_div && annul) begin
                        m_have = 1'b0;
                    end else if (in_done) begin
                        m_have = 1'b0;
                    end else if (!m_have && start && !annul) begin
                        m_have   = 1'b1;
                        m_t_acc  = m_cyc;
                        m_t_done = m_cyc + ((opb == '0) ? 1 : W + 1);
                        m_exp    = ref_div(signed_div, opa, opb);
                    end
                end
            end
            m_cyc++;
        end
    end

    // Issue one op (called just after a rising edge), hold start while
    // stalled, and check latency, stall length and the literal result.
    task automatic run_op(input string name, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        int          k;
        int          n_st;
        logic        got;
        logic [63:0] res;
        int          lat;
        lat        = (b == 32'd0) ? 1 : W + 1;
        signed_div = sgn;
        opa        = a;
        opb        = b;
        start      = 1'b1;
        got        = 1'b0;
        n_st       = 0;
        k          = 0;
        res        = '0;
        while (!got && k < 60) begin
            @(negedge clk);
            if (stall_req) n_st++;
            if (result_valid) begin
                got = 1'b1;
                res = result;
            end else begin
                k++;
            end
        end
        @(posedge clk);
        #1 start = 1'b0;
        check({name, "_valid_seen"}, got, 1);
        check({name, "_latency"}, k, lat);
        check({name, "_stall_cycles"}, n_st, lat);
        check({name, "_result"}, res, exp);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit          valid_seen;
        logic [31:0] a;
        logic [31:0] b;
        int          abort_at;
        bit          done;

        rst        = 1'b0;
        start      = 1'b0;
        signed_div = 1'b0;
        opa        = '0;
        opb        = '0;
        annul      = 1'b0;

        #1;
        check("init_stall_req", stall_req, 0);
        check("init_result_valid", result_valid, 0);
        check("init_result", result, 0);

        // Pin the reference model against hand-computed values.
        check("model_divu_100_7", ref_div(1'b0, 32'd100, 32'd7), 64'h0000_0002_0000_000E);
        check("model_div_m7_2", ref_div(1'b1, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        check("model_div_ovf", ref_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
        check("model_div_zero", ref_div(1'b1, 32'h0000_1234, 32'd0), 64'h0000_1234_FFFF_FFFF);

        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Directed cases with literal expectations.
        run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
        run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 64'h0000_0000_FFFF_FFFF);
        run_op("divu_by_zero", 1'b0, 32'h0000_1234, 32'd0, 64'h0000_1234_FFFF_FFFF);
        run_op("divu_7_100", 1'b0, 32'd7, 32'd100, 64'h0000_0007_0000_0000);

        // Abort at iteration 10.
        signed_div = 1'b0;
        opa        = 32'd1000;
        opb        = 32'd3;
        start      = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        annul = 1'b1;
        @(negedge clk);
        check("annul_stall_in_div", stall_req, 1);
        @(posedge clk);
        #1 annul = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("annul_idle_stall", stall_req, 0);
        valid_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            valid_seen = valid_seen | result_valid;
        end
        check("annul_no_valid", valid_seen, 0);
        @(posedge clk);
        #1;
        run_op("divu_9_3", 1'b0, 32'd9, 32'd3, 64'h0000_0000_0000_0003);

        // Reset asserted at iteration 20 while start is still held.
        signed_div = 1'b0;
        opa        = 32'hDEAD_BEEF;
        opb        = 32'd5;
        start      = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        #1 rst = 1'b0;
        #1;
        check("async_rst_stall_req", stall_req, 0);
        check("async_rst_result_valid", result_valid, 0);
        check("async_rst_result", result, 0);
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("post_rst_idle_stall", stall_req, 0);
        check("post_rst_idle_valid", result_valid, 0);
        @(posedge clk);
        #1;

        // Randomized traffic with occasional flushes; the compare process
        // checks every cycle against the model.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'd1;
                2:       b = 32'hFFFF_FFFF;
                3:       b = 32'($urandom_range(2, 15));
                default: b = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0:       a = 32'h8000_0000;
                1:       a = 32'($urandom_range(0, 100));
                default: a = $urandom;
            endcase
            signed_div = 1'($urandom_range(0, 1));
            opa        = a;
            opb        = b;
            start      = 1'b1;
            abort_at   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, W + 2)) : -1;
            done       = 1'b0;
            for (int k = 0; k < 60 && !done; k++) begin
                if (k == abort_at) begin
                    annul = 1'b1;
                    @(posedge clk);
                    #1 annul = 1'b0;
                    start = 1'b0;
                    done  = 1'b1;
                end else begin
                    @(negedge clk);
                    if (result_valid) done = 1'b1;
                    @(posedge clk);
                    #1;
                    if (done) start = 1'b0;
                end
            end
            if (!done) check("rand_completion", 0, 1);
            start = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
